// File: rtl/flight_pkg.sv
// Shared types and sizes for the flight control datapath.
// State encoding, bus widths and receiver channel indices.
package flight_pkg;

   localparam int RX_W       = 10;
   localparam int MOTOR_W    = 11;
   localparam int NUM_MOTORS = 4;
   localparam int NUM_CH     = 5;
   localparam int BUS_W      = MOTOR_W * NUM_MOTORS;

   typedef enum logic [2:0] {
      CH_PITCH = 3'd0,
      CH_ROLL  = 3'd1,
      CH_YAW   = 3'd2,
      CH_THR   = 3'd3,
      CH_SW    = 3'd4
   } ch_t;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      ARMED    = 2'd2,
      FAILSAFE = 2'd3
   } state_t;

endpackage

// File: rtl/arming_controller_if.sv
// Receiver/summer inputs and gated motor outputs of the arming controller.
// master = surrounding datapath, slave = the controller itself.
interface arming_controller_if;
   import flight_pkg::*;

   logic [RX_W-1:0]   throttle;
   logic [RX_W-1:0]   switch;
   logic [NUM_CH-1:0] pulse_valid;
   logic [BUS_W-1:0]  motor_in;
   logic [BUS_W-1:0]  motor_out;
   logic              armed;
   logic              failsafe;
   state_t            state;

   modport master (
      output throttle, switch, pulse_valid, motor_in,
      input  motor_out, armed, failsafe, state
   );

   modport slave (
      input  throttle, switch, pulse_valid, motor_in,
      output motor_out, armed, failsafe, state
   );

endinterface

// File: rtl/channel_watchdog.sv
// Per-channel pulse watchdog: counts ms ticks since the last pulse.
// Starts stale out of reset so nothing arms before every channel is heard.
module channel_watchdog #(
   parameter int FAILSAFE_MS = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic pulse_valid,
   output logic stale
);

   localparam int CW = $clog2(FAILSAFE_MS + 1);
   localparam logic [CW-1:0] LIMIT = CW'(FAILSAFE_MS);

   logic [CW-1:0] cnt;

   // fresh pulse clears (wins over a coincident tick), else saturating count
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= LIMIT;
      else if (pulse_valid)
         cnt <= '0;
      else if (tick && cnt < LIMIT)
         cnt <= cnt + 1'b1;
   end

   assign stale = (cnt >= LIMIT);

endmodule

// File: rtl/arming_controller.sv
// Arming/failsafe sequencer gating motor commands to the PWM generators.
// Define FAILSAFE_RAMP_EN for a per-ms ramp-down in FAILSAFE instead of a cut.
module arming_controller
   import flight_pkg::*;
#(
   parameter int              TICK_DIV    = 50000,
   parameter int              ARM_HOLD_MS = 1000,
   parameter int              FAILSAFE_MS = 100,
   parameter logic [RX_W-1:0] THR_LOW     = 10'd50,
   parameter logic [RX_W-1:0] SW_ARM_TH   = 10'd512
) (
   input logic                 clk,
   input logic                 rst,
   arming_controller_if.slave  bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(ARM_HOLD_MS + 1);

   logic [PW-1:0]     pre_q;
   logic              tick;
   logic [NUM_CH-1:0] stale;
   logic              all_fresh;
   logic              sw_on;
   logic              thr_low;
   logic              arm_ok;
   state_t            state_q;
   state_t            state_d;
   logic [HW-1:0]     hold_q;
   logic [HW-1:0]     hold_d;
   logic [HW-1:0]     hold_inc;
   logic [BUS_W-1:0]  motor_q;
   logic [BUS_W-1:0]  motor_d;
   logic              armed_q;
   logic              failsafe_q;

   assign tick = (pre_q == PW'(TICK_DIV - 1));

   // free-running 1 ms prescaler
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pre_q <= '0;
      else if (tick)
         pre_q <= '0;
      else
         pre_q <= pre_q + 1'b1;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_wd
      channel_watchdog #(
         .FAILSAFE_MS (FAILSAFE_MS)
      ) u_wd (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .pulse_valid (bus.pulse_valid[i]),
         .stale       (stale[i])
      );
   end

   assign all_fresh = ~|stale;
   assign sw_on     = (bus.switch >= SW_ARM_TH);
   assign thr_low   = (bus.throttle <= THR_LOW);
   assign arm_ok    = all_fresh && sw_on && thr_low;
   assign hold_inc  = hold_q + 1'b1;

   // next state and arm-hold timer; stale beats switch-off in ARMED
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      unique case (state_q)
         DISARMED: begin
            hold_d = '0;
            if (arm_ok)
               state_d = ARMING;
         end
         ARMING: begin
            if (!arm_ok)
               state_d = DISARMED;
            else if (tick) begin
               hold_d = hold_inc;
               if (hold_inc >= HW'(ARM_HOLD_MS))
                  state_d = ARMED;
            end
         end
         ARMED: begin
            if (!all_fresh)
               state_d = FAILSAFE;
            else if (!sw_on)
               state_d = DISARMED;
         end
         FAILSAFE: begin
            if (all_fresh && !sw_on)
               state_d = DISARMED;
         end
         default: state_d = DISARMED;
      endcase
   end

   // motor gating keyed on the state being entered, so gating is immediate
   always_comb begin
      motor_d = '0;
      unique case (state_d)
         ARMED: motor_d = bus.motor_in;
         FAILSAFE: begin
`ifdef FAILSAFE_RAMP_EN
            motor_d = motor_q;
            for (int i = 0; i < NUM_MOTORS; i++) begin
               if (tick && motor_q[i*MOTOR_W +: MOTOR_W] != '0)
                  motor_d[i*MOTOR_W +: MOTOR_W] =
                     motor_q[i*MOTOR_W +: MOTOR_W] - 1'b1;
            end
`else
            motor_d = '0;
`endif
         end
         default: motor_d = '0;
      endcase
   end

   // state and all outputs registered together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= DISARMED;
         hold_q     <= '0;
         motor_q    <= '0;
         armed_q    <= 1'b0;
         failsafe_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         motor_q    <= motor_d;
         armed_q    <= (state_d == ARMED);
         failsafe_q <= (state_d == FAILSAFE);
      end
   end

   assign bus.motor_out = motor_q;
   assign bus.armed     = armed_q;
   assign bus.failsafe  = failsafe_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_arming_controller.sv
// Directed bench for arming_controller (TICK_DIV=10, hold 4, failsafe 3).
// Tick edges are predicted from the reset release edge.
module tb_arming_controller;
   import flight_pkg::*;

   localparam logic [BUS_W-1:0] M_A  = {11'd0, 11'd0, 11'd0, 11'd600};
   localparam logic [BUS_W-1:0] M_B  = {11'd0, 11'd0, 11'd1, 11'd600};
   localparam logic [BUS_W-1:0] M_R1 = {11'd0, 11'd0, 11'd0, 11'd599};
   localparam logic [BUS_W-1:0] M_R2 = {11'd0, 11'd0, 11'd0, 11'd598};
   localparam logic [BUS_W-1:0] M_Z  = '0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   int                rel_base = 0;
   logic [NUM_CH-1:0] mask = '0;
   int                last_clr [NUM_CH];

   arming_controller_if bus ();

   arming_controller #(
      .TICK_DIV    (10),
      .ARM_HOLD_MS (4),
      .FAILSAFE_MS (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // receiver strobes for every channel enabled in mask, every 20 clocks
   initial begin
      bus.pulse_valid = '0;
      for (int i = 0; i < NUM_CH; i++) last_clr[i] = 0;
      forever begin
         repeat (19) @(posedge clk);
         #1;
         bus.pulse_valid = mask;
         for (int i = 0; i < NUM_CH; i++)
            if (mask[i]) last_clr[i] = cyc + 1;
         @(posedge clk);
         #1 bus.pulse_valid = '0;
      end
   end

   function automatic int next_tick(input int c);
      return rel_base + 10 * ((c - rel_base) / 10 + 1);
   endfunction

   task automatic step_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      bus.throttle = 10'd0;
      bus.switch   = 10'd900;
      bus.motor_in = M_A;
      mask         = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.state !== DISARMED) begin
         errors++;
         $display("FAIL rst_state got %0d want %0d", bus.state, DISARMED);
      end
      checks++;
      if (bus.motor_out !== M_Z) begin
         errors++;
         $display("FAIL rst_motor got %0h want 0", bus.motor_out);
      end
      checks++;
      if (bus.armed !== 1'b0 || bus.failsafe !== 1'b0) begin
         errors++;
         $display("FAIL rst_flags got %b%b want 00", bus.armed, bus.failsafe);
      end
      rst = 1'b0;
      rel_base = cyc;
      repeat (50) @(posedge clk);
      #1;
      checks++;
      if (bus.state !== DISARMED || bus.motor_out !== M_Z) begin
         errors++;
         $display("FAIL stale_hold got st=%0d m=%0h want st=0 m=0",
                  bus.state, bus.motor_out);
      end
   endtask

   task automatic test_arm;
      int n;
      int s;
      int exp_c;
      mask = 5'h1F;
      n = 0;
      while (bus.state !== ARMING && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.state !== ARMING) begin
         errors++;
         $display("FAIL arm_enter got %0d want %0d", bus.state, ARMING);
      end
      s = cyc;
      exp_c = next_tick(s) + 30;
      n = 0;
      while (bus.state === ARMING && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.state !== ARMED || cyc != exp_c) begin
         errors++;
         $display("FAIL arm_time got st=%0d cyc=%0d want st=2 cyc=%0d",
                  bus.state, cyc, exp_c);
      end
      checks++;
      if (bus.armed !== 1'b1 || bus.failsafe !== 1'b0) begin
         errors++;
         $display("FAIL arm_flags got %b%b want 10", bus.armed, bus.failsafe);
      end
      checks++;
      if (bus.motor_out !== M_A) begin
         errors++;
         $display("FAIL arm_motor got %0h want %0h", bus.motor_out, M_A);
      end
      bus.motor_in = M_B;
      #1;
      checks++;
      if (bus.motor_out !== M_A) begin
         errors++;
         $display("FAIL lat_hold got %0h want %0h", bus.motor_out, M_A);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.motor_out !== M_B) begin
         errors++;
         $display("FAIL lat_one got %0h want %0h", bus.motor_out, M_B);
      end
   endtask

   task automatic test_throttle_abort;
      int n;
      int s;
      int exp_c;
      bus.switch = 10'd100;
      @(posedge clk);
      #1;
      checks++;
      if (bus.state !== DISARMED || bus.motor_out !== M_Z) begin
         errors++;
         $display("FAIL sw_off got st=%0d m=%0h want st=0 m=0",
                  bus.state, bus.motor_out);
      end
      bus.switch = 10'd900;
      @(posedge clk);
      #1;
      s = cyc;
      step_to(next_tick(s) + 10);
      checks++;
      if (bus.state !== ARMING || bus.motor_out !== M_Z) begin
         errors++;
         $display("FAIL mid_arm got st=%0d m=%0h want st=1 m=0",
                  bus.state, bus.motor_out);
      end
      bus.throttle = 10'd300;
      @(posedge clk);
      #1;
      checks++;
      if (bus.state !== DISARMED) begin
         errors++;
         $display("FAIL thr_abort got %0d want %0d", bus.state, DISARMED);
      end
      bus.throttle = 10'd0;
      @(posedge clk);
      #1;
      s = cyc;
      exp_c = next_tick(s) + 30;
      n = 0;
      while (bus.state === ARMING && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.state !== ARMED || cyc != exp_c) begin
         errors++;
         $display("FAIL rearm_time got st=%0d cyc=%0d want st=2 cyc=%0d",
                  bus.state, cyc, exp_c);
      end
   endtask

   task automatic test_failsafe;
      int n;
      int exp_c;
      int t;
      mask = 5'h1B;
      repeat (2) @(posedge clk);
      #1;
      exp_c = next_tick(last_clr[2]) + 21;
      n = 0;
      while (bus.state === ARMED && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.state !== FAILSAFE || cyc != exp_c) begin
         errors++;
         $display("FAIL fs_time got st=%0d cyc=%0d want st=3 cyc=%0d",
                  bus.state, cyc, exp_c);
      end
      checks++;
      if (bus.failsafe !== 1'b1 || bus.armed !== 1'b0) begin
         errors++;
         $display("FAIL fs_flags got %b%b want 01", bus.armed, bus.failsafe);
      end
      t = next_tick(cyc);
`ifdef FAILSAFE_RAMP_EN
      checks++;
      if (bus.motor_out !== M_B) begin
         errors++;
         $display("FAIL ramp0 got %0h want %0h", bus.motor_out, M_B);
      end
      step_to(t);
      checks++;
      if (bus.motor_out !== M_R1) begin
         errors++;
         $display("FAIL ramp1 got %0h want %0h", bus.motor_out, M_R1);
      end
      step_to(t + 10);
      checks++;
      if (bus.motor_out !== M_R2) begin
         errors++;
         $display("FAIL ramp2 got %0h want %0h", bus.motor_out, M_R2);
      end
`else
      checks++;
      if (bus.motor_out !== M_Z) begin
         errors++;
         $display("FAIL fs_cut got %0h want 0", bus.motor_out);
      end
      step_to(t);
      checks++;
      if (bus.motor_out !== M_Z) begin
         errors++;
         $display("FAIL fs_hold got %0h want 0", bus.motor_out);
      end
`endif
   endtask

   task automatic test_failsafe_exit;
      int n;
      int s;
      int exp_c;
      mask = 5'h1F;
      bus.switch = 10'd900;
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (bus.state !== FAILSAFE || bus.failsafe !== 1'b1) begin
         errors++;
         $display("FAIL fs_sticky got st=%0d fs=%b want st=3 fs=1",
                  bus.state, bus.failsafe);
      end
      bus.switch = 10'd100;
      @(posedge clk);
      #1;
      checks++;
      if (bus.state !== DISARMED || bus.motor_out !== M_Z
          || bus.failsafe !== 1'b0) begin
         errors++;
         $display("FAIL fs_exit got st=%0d m=%0h fs=%b want st=0 m=0 fs=0",
                  bus.state, bus.motor_out, bus.failsafe);
      end
      bus.switch = 10'd900;
      @(posedge clk);
      #1;
      s = cyc;
      checks++;
      if (bus.state !== ARMING) begin
         errors++;
         $display("FAIL fs_rearm got %0d want %0d", bus.state, ARMING);
      end
      exp_c = next_tick(s) + 30;
      n = 0;
      while (bus.state === ARMING && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.state !== ARMED || cyc != exp_c) begin
         errors++;
         $display("FAIL fs_rearm_time got st=%0d cyc=%0d want st=2 cyc=%0d",
                  bus.state, cyc, exp_c);
      end
   endtask

   task automatic test_stale_priority;
      int t3;
      mask = 5'h1B;
      repeat (2) @(posedge clk);
      #1;
      t3 = next_tick(last_clr[2]) + 20;
      step_to(t3);
      checks++;
      if (bus.state !== ARMED) begin
         errors++;
         $display("FAIL pre_stale got %0d want %0d", bus.state, ARMED);
      end
      bus.switch = 10'd100;
      @(posedge clk);
      #1;
      checks++;
      if (bus.state !== FAILSAFE || bus.failsafe !== 1'b1) begin
         errors++;
         $display("FAIL stale_prio got st=%0d fs=%b want st=3 fs=1",
                  bus.state, bus.failsafe);
      end
   endtask

   task automatic test_async_reset;
      int n;
      mask = 5'h1F;
      bus.switch = 10'd100;
      n = 0;
      while (bus.state !== DISARMED && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.state !== DISARMED) begin
         errors++;
         $display("FAIL ar_disarm got %0d want %0d", bus.state, DISARMED);
      end
      bus.switch = 10'd900;
      n = 0;
      while (bus.state !== ARMED && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (bus.state !== ARMED || bus.motor_out !== M_B) begin
         errors++;
         $display("FAIL ar_armed got st=%0d m=%0h want st=2 m=%0h",
                  bus.state, bus.motor_out, M_B);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if (bus.state !== DISARMED || bus.motor_out !== M_Z
          || bus.armed !== 1'b0) begin
         errors++;
         $display("FAIL async_rst got st=%0d m=%0h a=%b want st=0 m=0 a=0",
                  bus.state, bus.motor_out, bus.armed);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_arm();
      test_throttle_abort();
      test_failsafe();
      test_failsafe_exit();
      test_stale_priority();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
